// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one sequential multiplier core among NREQ requesters.
// Latency: req to gnt is 1 cycle, req to rsp_valid is M+3 cycles; a hung core is aborted by a watchdog.
module mult_share_ctrl #(
  parameter int N       = 4,
  parameter int M       = 4,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*M-1:0]   req_b,
  output logic [NREQ-1:0]     gnt,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [N+M-1:0]      rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                mul_data_rdy,
  output logic [N-1:0]        mul_mult1,
  output logic [M-1:0]        mul_mult2,
  input  logic                mul_result_rdy,
  input  logic [N+M-1:0]      mul_result
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic [WDW-1:0] wd;

  // Descending scan so the set bit closest to ptr (upward, wrapping) is the last to overwrite pick.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        pick     = IDW'((int'(ptr) + k) % NREQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      winner       <= '0;
      wd           <= '0;
      gnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      mul_data_rdy <= 1'b0;
      mul_mult1    <= '0;
      mul_mult2    <= '0;
    end else begin
      gnt          <= '0;
      mul_data_rdy <= 1'b0;
      rsp_valid    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            winner       <= pick;
            mul_mult1    <= req_a[int'(pick)*N +: N];
            mul_mult2    <= req_b[int'(pick)*M +: M];
            gnt          <= NREQ'(1) << pick;
            mul_data_rdy <= 1'b1;
            busy         <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a coincident timeout.
          if (mul_result_rdy) begin
            rsp_data  <= mul_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            state     <= S_RESP;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            state     <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESP: begin
          ptr   <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
